// File: rtl/regfile_wsel_sb.sv
// regfile_wsel_sb: registered two-port write-enable decoder with same-address arbitration and a busy scoreboard.
// Optional build macro REGFILE_ZERO_LOCK_EN hardwires register 0 (never written, never busy).
module regfile_wsel_sb #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wa_en,
  input  logic [ADDR_W-1:0]   wa_addr,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic [ADDR_W-1:0]   rs_addr,
  output logic [NUM_REGS-1:0] wen_a,
  output logic [NUM_REGS-1:0] wen_b,
  output logic [NUM_REGS-1:0] busy,
  output logic                rs_busy,
  output logic                collision,
  output logic                err_dup,
  output logic                err_spur
);

  logic [NUM_REGS-1:0] wen_a_q, wen_a_d;
  logic [NUM_REGS-1:0] wen_b_q, wen_b_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                collision_q, collision_d;
  logic                err_dup_q, err_dup_d;
  logic                err_spur_q, err_spur_d;

  logic                wa_ok, wb_ok, iss_ok;
  logic [NUM_REGS-1:0] keep_mask;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic                same_addr;

`ifdef REGFILE_ZERO_LOCK_EN
  // Register 0 is hardwired: its address never produces a write, an issue or a busy bit.
  assign wa_ok     = (wa_addr != '0);
  assign wb_ok     = (wb_addr != '0);
  assign iss_ok    = (iss_addr != '0);
  assign keep_mask = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
  assign wa_ok     = 1'b1;
  assign wb_ok     = 1'b1;
  assign iss_ok    = 1'b1;
  assign keep_mask = '1;
`endif

  always_comb begin
    wen_a_d   = '0;
    wen_b_d   = '0;
    set_vec   = '0;
    same_addr = (wa_addr == wb_addr);

    if (wa_en && wa_ok)
      wen_a_d[wa_addr] = 1'b1;
    // Port A wins a same-address write; port B is dropped and never reaches the scoreboard.
    if (wb_en && wb_ok && !(wa_en && same_addr))
      wen_b_d[wb_addr] = 1'b1;
    collision_d = wa_en & wb_en & same_addr & wa_ok;

    if (iss_en && iss_ok)
      set_vec[iss_addr] = 1'b1;
    clr_vec = wen_a_d | wen_b_d;

    // A new issue supersedes a same-cycle writeback of the old producer.
    busy_d     = (set_vec | (busy_q & ~clr_vec)) & keep_mask;
    err_dup_d  = err_dup_q | (iss_en & iss_ok & busy_q[iss_addr]);
    err_spur_d = err_spur_q | (|(clr_vec & ~busy_q & ~set_vec));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wen_a_q     <= '0;
      wen_b_q     <= '0;
      busy_q      <= '0;
      collision_q <= 1'b0;
      err_dup_q   <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      wen_a_q     <= wen_a_d;
      wen_b_q     <= wen_b_d;
      busy_q      <= busy_d;
      collision_q <= collision_d;
      err_dup_q   <= err_dup_d;
      err_spur_q  <= err_spur_d;
    end
  end

  assign wen_a     = wen_a_q;
  assign wen_b     = wen_b_q;
  assign busy      = busy_q;
  assign rs_busy   = busy_q[rs_addr];
  assign collision = collision_q;
  assign err_dup   = err_dup_q;
  assign err_spur  = err_spur_q;

endmodule

// File: tb/tb_regfile_wsel_sb.sv
// tb_regfile_wsel_sb: directed test-plan sequences plus biased random traffic against a per-register scoreboard model.
// Honours REGFILE_ZERO_LOCK_EN when the whole build defines it.
module tb_regfile_wsel_sb;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2**ADDR_W;
`ifdef REGFILE_ZERO_LOCK_EN
  localparam bit ZERO_LOCK = 1'b1;
`else
  localparam bit ZERO_LOCK = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                wa_en = 1'b0;
  logic [ADDR_W-1:0]   wa_addr = '0;
  logic                wb_en = 1'b0;
  logic [ADDR_W-1:0]   wb_addr = '0;
  logic                iss_en = 1'b0;
  logic [ADDR_W-1:0]   iss_addr = '0;
  logic [ADDR_W-1:0]   rs_addr = '0;
  logic [NUM_REGS-1:0] wen_a, wen_b, busy;
  logic                rs_busy, collision, err_dup, err_spur;

  int num_vectors    = 0;
  int num_miscompares = 0;

  bit busy_m [NUM_REGS];
  bit dup_m, spur_m;
  bit model_valid = 1'b0;

  regfile_wsel_sb #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rs_addr(rs_addr),
    .wen_a(wen_a), .wen_b(wen_b), .busy(busy), .rs_busy(rs_busy),
    .collision(collision), .err_dup(err_dup), .err_spur(err_spur)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_vectors++;
    if (got !== exp) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit locked(input int addr);
    return ZERO_LOCK && (addr == 0);
  endfunction

  // One clock cycle: drive inputs, predict from the register-level rules, then compare after the edge.
  task automatic applyStimulus(input bit rst, input bit a_en, input int a_addr, input bit b_en,
                               input int b_addr, input bit i_en, input int i_addr, input int r_addr);
    logic [63:0] exp_wa, exp_wb, exp_busy;
    bit exp_col, collide, issue_ok;
    reset    = rst;
    wa_en    = a_en;   wa_addr  = a_addr[ADDR_W-1:0];
    wb_en    = b_en;   wb_addr  = b_addr[ADDR_W-1:0];
    iss_en   = i_en;   iss_addr = i_addr[ADDR_W-1:0];
    rs_addr  = r_addr[ADDR_W-1:0];
    #1;
    if (model_valid) checkOutput("rs_busy", {63'd0, rs_busy}, {63'd0, busy_m[r_addr]});

    exp_wa = 0; exp_wb = 0; exp_col = 0;
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      dup_m = 0; spur_m = 0;
    end else begin
      collide  = a_en && b_en && (a_addr == b_addr);
      issue_ok = i_en && !locked(i_addr);
      if (a_en && !locked(a_addr)) exp_wa = 64'd1 << a_addr;
      if (b_en && !collide && !locked(b_addr)) exp_wb = 64'd1 << b_addr;
      exp_col = collide && !locked(a_addr);
      if (issue_ok && busy_m[i_addr]) dup_m = 1;
      if (exp_wa != 0 && !busy_m[a_addr] && !(issue_ok && i_addr == a_addr)) spur_m = 1;
      if (exp_wb != 0 && !busy_m[b_addr] && !(issue_ok && i_addr == b_addr)) spur_m = 1;
      if (exp_wa != 0) busy_m[a_addr] = 0;
      if (exp_wb != 0) busy_m[b_addr] = 0;
      if (issue_ok) busy_m[i_addr] = 1;
    end
    exp_busy = 0;
    for (int i = 0; i < NUM_REGS; i++) exp_busy[i] = busy_m[i];

    @(posedge clock);
    #1;
    model_valid = 1'b1;
    checkOutput("wen_a", {32'd0, wen_a}, exp_wa);
    checkOutput("wen_b", {32'd0, wen_b}, exp_wb);
    checkOutput("busy", {32'd0, busy}, exp_busy);
    checkOutput("collision", {63'd0, collision}, {63'd0, exp_col});
    checkOutput("err_dup", {63'd0, err_dup}, {63'd0, dup_m});
    checkOutput("err_spur", {63'd0, err_spur}, {63'd0, spur_m});
  endtask

  task automatic idle(input int r_addr);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, r_addr);
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NUM_REGS-1));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    $display("[TB] starting, zero lock = %0d", ZERO_LOCK);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_busy", {32'd0, busy}, 64'd0);

    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0);
    checkOutput("tp_wen_a5", {32'd0, wen_a}, 64'h20);

    applyStimulus(0, 1, 9, 1, 9, 0, 0, 0);
    checkOutput("tp_col_wen_a", {32'd0, wen_a}, 64'h200);
    checkOutput("tp_col_pulse", {63'd0, collision}, 64'd1);
    idle(0);
    checkOutput("tp_col_drop", {63'd0, collision}, 64'd0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 7);
    idle(7);
    checkOutput("tp_rs_busy7", {63'd0, rs_busy}, 64'd1);
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 7);
    checkOutput("tp_clear7", {63'd0, busy[7]}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 7);
    applyStimulus(0, 1, 7, 0, 0, 1, 7, 7);
    checkOutput("tp_issue_wins", {63'd0, busy[7]}, 64'd1);
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 7);

    applyStimulus(0, 0, 0, 0, 0, 1, 3, 3);
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 3);
    idle(3);
    checkOutput("tp_dup_sticky", {63'd0, err_dup}, 64'd1);
    applyStimulus(0, 0, 0, 1, 12, 0, 0, 12);
    checkOutput("tp_spur", {63'd0, err_spur}, 64'd1);
    applyStimulus(1, 1, 4, 1, 6, 1, 8, 3);
    checkOutput("tp_mid_reset", {32'd0, busy | wen_a | wen_b}, 64'd0);

    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("tp_zero_wen", {32'd0, wen_a}, ZERO_LOCK ? 64'd0 : 64'd1);
    idle(0);
    checkOutput("tp_zero_busy", {63'd0, busy[0]}, ZERO_LOCK ? 64'd0 : 64'd1);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(0, 1, i, 1, (i + 1) % NUM_REGS, 0, 0, i);
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(0, 0, 0, 1, i, 1, i, i);

    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 29) == 0,
                    $urandom_range(0, 1) == 1, pick_addr(),
                    $urandom_range(0, 1) == 1, pick_addr(),
                    $urandom_range(0, 2) == 0, pick_addr(), pick_addr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wsel_sb.md
# regfile_wsel_sb

Parametrised registered write-select decoder with an integrated busy scoreboard for the register file. It turns two writeback ports' binary addresses into registered one-hot write enables, arbitrates same-address writes between the ports, and tracks which registers have an issued but not yet written-back result. It sits between the writeback stage and the register-file write-enable inputs, and also feeds the operand-hazard check in issue.

## Interface
Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 2**ADDR_W, derived; number of registers and the width of each one-hot vector.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wa_en  in  1  writeback port A valid.
- wa_addr  in  ADDR_W  port A destination.
- wb_en  in  1  writeback port B valid.
- wb_addr  in  ADDR_W  port B destination.
- iss_en  in  1  issue of an instruction with a destination.
- iss_addr  in  ADDR_W  destination being issued.
- rs_addr  in  ADDR_W  source operand queried for a hazard.
- wen_a  out  NUM_REGS  registered one-hot write enable for port A.
- wen_b  out  NUM_REGS  registered one-hot write enable for port B.
- busy  out  NUM_REGS  scoreboard vector.
- rs_busy  out  1  combinational: busy[rs_addr].
- collision  out  1  registered pulse: port B was dropped.
- err_dup  out  1  sticky: issue to a register already busy.
- err_spur  out  1  sticky: writeback to a register not busy.

## Operation
- Decode:
  - wen_a is next-cycle decode(wa_addr) when wa_en is high, otherwise all zeros.
  - wen_b is the same for port B.
  - Each vector has at most one bit set.
- Collision:
  - Applies when wa_en, wb_en and wa_addr == wb_addr are all true.
  - Port A wins. wen_b is all zeros next cycle and collision pulses for one cycle.
  - wen_a and wen_b are never both set for the same bit.
- Scoreboard, per register r, evaluated each cycle:
  - set = iss_en & iss_addr == r.
  - clr = an effective (post-arbitration) writeback to r.
  - busy[r]: next = set ? 1 : (clr ? 0 : busy[r]).
  - Issue beats a same-cycle writeback to the same register, because the new producer supersedes the old one.
  - A single cycle may both issue one register and clear up to two others.
- Errors, sticky until reset:
  - err_dup sets when iss_en is high and busy[iss_addr] is already 1.
  - err_spur sets on an effective writeback to r while busy[r] == 0 and r is not being set that cycle.
  - A dropped port-B write is not checked for err_spur.
- rs_busy reflects the current registered busy value. It does not bypass a same-cycle writeback.

## Timing
- Reset, synchronous: when reset is high at an edge, the following all read 0 after that edge:
  - wen_a and wen_b (all zeros)
  - busy (all zeros)
  - collision, err_dup and err_spur
- Inputs presented during the reset cycle are ignored.
- Reset asserted mid-operation discards all pending busy bits and any write enables from the previous cycle.
- Decode latency is 1 cycle. Inputs sampled at edge t produce wen_a, wen_b and collision valid from t until t+1. The register file samples them at t+1.
- Busy latency is 1 cycle. Issue or writeback at edge t is visible on busy and rs_busy after t.
- Address wrap: every ADDR_W-bit value maps to a valid register, so there is no out-of-range case.

## Configuration
- REGFILE_ZERO_LOCK_EN defined:
  - Register 0 is hardwired.
  - Writes to address 0 give no wen bit, and no collision is flagged for address 0.
  - Issue to address 0 is ignored: no busy set and no err_dup.
  - busy[0] is constant 0, and writebacks to 0 never raise err_spur.
- Not defined: register 0 behaves like every other register.

## Test plan
- Reset, then wa_en=1, wa_addr=5 -> next cycle wen_a=0x00000020, wen_b=0, collision=0 (ADDR_W=5).
- wa_en=wb_en=1, both addresses 9 -> next cycle wen_a=0x00000200, wen_b=0, collision=1 for exactly one cycle.
- Issue to 7, then rs_addr=7 -> rs_busy=1 the cycle after issue. Writeback A to 7 -> busy[7]=0 one cycle later with no errors. Issue to 7 and writeback to 7 in the same cycle -> busy[7] stays 1.
- Issue to 3 twice without a writeback -> err_dup=1 and it stays set. Writeback to 12 with busy[12]=0 -> err_spur=1. Reset asserted mid-sequence -> all outputs 0 next cycle.
- REGFILE_ZERO_LOCK_EN defined: wa_addr=0 with issue to 0 -> wen_a=0, busy[0]=0, no errors. Undefined: wen_a=0x00000001 and busy[0]=1.
- ADDR_W=3 build: sweep all 8 addresses on both ports -> each wen vector is one-hot and matches decode.
